adv_input_ctrl: RTL and testbench

Upstream front end of the room state machine. It conditions the four raw direction buttons into clean, single-cycle, mutually exclusive move pulses n/s/e/w. It also tracks sword possession and drives the v input, using the sw (sword-room) indication fed back from the room machine. It latches game-over from the room machine's d/win outputs and locks out further moves until reset.

---
 rtl/adv_pkg.sv | 15 +
 rtl/btn_debounce.sv | 54 +++++
 rtl/adv_input_ctrl.sv | 80 ++++++++
 tb/tb_adv_input_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/adv_pkg.sv
// Shared types and constants for the adventure-game input front end.
package adv_pkg;

  typedef enum logic {NO_SWORD, HAS_SWORD} sword_state_t;
  typedef enum logic {PLAY, OVER} game_state_t;

  localparam int unsigned DIR_N = 0;
  localparam int unsigned DIR_S = 1;
  localparam int unsigned DIR_E = 2;
  localparam int unsigned DIR_W = 3;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int unsigned DB_W_DEFAULT            = 3;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, stability counter, accepted level and
// a registered single-cycle pulse on each accepted 0->1 transition.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = adv_pkg::DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned DB_W            = adv_pkg::DB_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            stable_q, stable_d;
  logic            press_q, press_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    // The DEBOUNCE_CYCLES-th consecutive differing sample is accepted.
    if (sync2_q != stable_q) begin
      if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = stable_d & ~stable_q;
  end

  // Accepted level resets high so a button held through reset stays silent.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/adv_input_ctrl.sv
// Input front end for the room machine: debounced, arbitrated move pulses,
// sword possession tracking and game-over lockout.
module adv_input_ctrl
  import adv_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = adv_pkg::DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned DB_W            = adv_pkg::DB_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic btn_s,
  input  logic btn_e,
  input  logic btn_w,
  input  logic sw,
  input  logic d,
  input  logic win,
  output logic n,
  output logic s,
  output logic e,
  output logic w,
  output logic v,
  output logic game_over
);

  logic [3:0]   btn_raw;
  logic [3:0]   press;
  logic [3:0]   dir_q, dir_d;
  sword_state_t sword_q, sword_d;
  game_state_t  game_q, game_d;

  assign btn_raw[DIR_N] = btn_n;
  assign btn_raw[DIR_S] = btn_s;
  assign btn_raw[DIR_E] = btn_e;
  assign btn_raw[DIR_W] = btn_w;

  for (genvar i = 0; i < 4; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_W           (DB_W)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn_raw[i]),
      .press  (press[i])
    );
  end

  // Simultaneous presses are dropped entirely; OVER freezes moves and sword.
  always_comb begin
    sword_d = sword_q;
    game_d  = game_q;
    dir_d   = '0;
    if (game_q == PLAY) begin
      if (d || win) game_d = OVER;
      if (sw) sword_d = HAS_SWORD;
      if ($onehot(press)) dir_d = press;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sword_q <= NO_SWORD;
      game_q  <= PLAY;
      dir_q   <= '0;
    end else begin
      sword_q <= sword_d;
      game_q  <= game_d;
      dir_q   <= dir_d;
    end
  end

  assign n         = dir_q[DIR_N];
  assign s         = dir_q[DIR_S];
  assign e         = dir_q[DIR_E];
  assign w         = dir_q[DIR_W];
  assign v         = (sword_q == HAS_SWORD);
  assign game_over = (game_q == OVER);

endmodule

// File: tb/tb_adv_input_ctrl.sv
// Self-checking bench for adv_input_ctrl: directed segment table, exact-latency
// sequences and randomized traffic against a sample-window reference model.
module tb_adv_input_ctrl;
  import adv_pkg::*;

  localparam int DC = 4;
  localparam logic [3:0] BN = 4'b0001;
  localparam logic [3:0] BS = 4'b0010;
  localparam logic [3:0] BE = 4'b0100;
  localparam logic [3:0] BW = 4'b1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [3:0] btn = '0;
  logic       sw = 1'b0, d = 1'b0, win = 1'b0;
  logic       n, s, e, w, v, game_over;

  adv_input_ctrl #(.DEBOUNCE_CYCLES(DC), .DB_W(3)) dut (
    .clk(clk), .reset(reset),
    .btn_n(btn[DIR_N]), .btn_s(btn[DIR_S]), .btn_e(btn[DIR_E]), .btn_w(btn[DIR_W]),
    .sw(sw), .d(d), .win(win),
    .n(n), .s(s), .e(e), .w(w), .v(v), .game_over(game_over)
  );

  int checks = 0;
  int errors = 0;
  int cnt[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a level is accepted once the last DC synchronized
  // samples all disagree with the currently accepted level.
  logic [3:0]    m_s1, m_s2, m_stab, m_rise, m_dir;
  logic [DC-1:0] m_hist [4];
  logic          m_v, m_over;

  task automatic model_step();
    logic [3:0] nstab, nrise, ndir;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stab = '1; m_rise = '0; m_dir = '0;
      m_v = 1'b0; m_over = 1'b0;
      for (int i = 0; i < 4; i++) m_hist[i] = '1;
    end else begin
      ndir = (!m_over && $countones(m_rise) == 1) ? m_rise : 4'b0;
      for (int i = 0; i < 4; i++) begin
        m_hist[i] = {m_hist[i][DC-2:0], m_s2[i]};
        nstab[i]  = (m_hist[i] == {DC{~m_stab[i]}}) ? m_s2[i] : m_stab[i];
        nrise[i]  = nstab[i] & ~m_stab[i];
      end
      m_v    = m_v | (sw & ~m_over);
      m_over = m_over | d | win;
      m_dir  = ndir;
      m_stab = nstab;
      m_rise = nrise;
      m_s2   = m_s1;
      m_s1   = btn;
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("model", {v, game_over, w, e, s, n}, {m_v, m_over, m_dir});
    cnt[DIR_N] += int'(n);
    cnt[DIR_S] += int'(s);
    cnt[DIR_E] += int'(e);
    cnt[DIR_W] += int'(w);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] b;
    logic       sw, d, win;
    int         ncyc;
    int         en, es, ee, ew;
    logic       ev, eg;
  } seg_t;

  seg_t segs[$];

  function automatic void add(logic rst, logic [3:0] b, logic sw_, logic d_, logic win_,
                              int nc, int en, int es, int ee, int ew, logic ev, logic eg);
    seg_t t;
    t.rst = rst; t.b = b; t.sw = sw_; t.d = d_; t.win = win_; t.ncyc = nc;
    t.en = en; t.es = es; t.ee = ee; t.ew = ew; t.ev = ev; t.eg = eg;
    segs.push_back(t);
  endfunction

  initial begin
    //  rst  btn      sw d  win cyc  n  s  e  w  v  g
    add(1, 4'b0,      0, 0, 0,  2,   0, 0, 0, 0, 0, 0);
    add(0, 4'b0,      0, 0, 0,  8,   0, 0, 0, 0, 0, 0);
    add(0, BE,        0, 0, 0,  20,  0, 0, 1, 0, 0, 0);
    add(0, 4'b0,      0, 0, 0,  10,  0, 0, 0, 0, 0, 0);
    add(0, BN,        0, 0, 0,  1,   0, 0, 0, 0, 0, 0);
    add(0, 4'b0,      0, 0, 0,  1,   0, 0, 0, 0, 0, 0);
    add(0, BN,        0, 0, 0,  1,   0, 0, 0, 0, 0, 0);
    add(0, 4'b0,      0, 0, 0,  6,   0, 0, 0, 0, 0, 0);
    add(0, BN,        0, 0, 0,  10,  1, 0, 0, 0, 0, 0);
    add(0, 4'b0,      0, 0, 0,  10,  0, 0, 0, 0, 0, 0);
    add(0, BS | BW,   0, 0, 0,  12,  0, 0, 0, 0, 0, 0);
    add(0, 4'b0,      0, 0, 0,  10,  0, 0, 0, 0, 0, 0);
    add(0, BS,        0, 0, 0,  10,  0, 1, 0, 0, 0, 0);
    add(0, 4'b0,      0, 0, 0,  10,  0, 0, 0, 0, 0, 0);
    add(0, 4'b0,      1, 0, 0,  1,   0, 0, 0, 0, 1, 0);
    add(0, BW,        0, 0, 0,  10,  0, 0, 0, 1, 1, 0);
    add(0, 4'b0,      0, 0, 0,  10,  0, 0, 0, 0, 1, 0);
    add(1, 4'b0,      0, 0, 0,  2,   0, 0, 0, 0, 0, 0);
    add(0, 4'b0,      0, 0, 0,  8,   0, 0, 0, 0, 0, 0);
    add(0, 4'b0,      0, 0, 1,  1,   0, 0, 0, 0, 0, 1);
    add(0, 4'b0,      1, 0, 0,  1,   0, 0, 0, 0, 0, 1);
    add(0, BN,        0, 0, 0,  10,  0, 0, 0, 0, 0, 1);
    add(0, 4'b0,      0, 1, 1,  5,   0, 0, 0, 0, 0, 1);
    add(1, 4'b0,      0, 0, 0,  2,   0, 0, 0, 0, 0, 0);
    add(0, 4'b0,      0, 0, 0,  8,   0, 0, 0, 0, 0, 0);
    add(0, BN,        0, 0, 0,  10,  1, 0, 0, 0, 0, 0);
    add(0, 4'b0,      0, 0, 0,  10,  0, 0, 0, 0, 0, 0);
    add(0, BE,        0, 0, 0,  10,  0, 0, 1, 0, 0, 0);
    add(1, BE,        0, 0, 0,  2,   0, 0, 0, 0, 0, 0);
    add(0, BE,        0, 0, 0,  10,  0, 0, 0, 0, 0, 0);
    add(0, 4'b0,      0, 0, 0,  10,  0, 0, 0, 0, 0, 0);
    add(0, BE,        0, 0, 0,  10,  0, 0, 1, 0, 0, 0);
    add(0, 4'b0,      0, 0, 0,  10,  0, 0, 0, 0, 0, 0);
    add(0, BE,        0, 0, 0,  4,   0, 0, 0, 0, 0, 0);
    add(1, 4'b0,      0, 0, 0,  2,   0, 0, 0, 0, 0, 0);
    add(0, 4'b0,      0, 0, 0,  10,  0, 0, 0, 0, 0, 0);

    foreach (segs[k]) begin
      reset = segs[k].rst; btn = segs[k].b;
      sw = segs[k].sw; d = segs[k].d; win = segs[k].win;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      repeat (segs[k].ncyc) cyc();
      check($sformatf("seg%0d pulses", k),
            {cnt[DIR_N][7:0], cnt[DIR_S][7:0], cnt[DIR_E][7:0], cnt[DIR_W][7:0]},
            {segs[k].en[7:0], segs[k].es[7:0], segs[k].ee[7:0], segs[k].ew[7:0]});
      check($sformatf("seg%0d v/game_over", k), {v, game_over}, {segs[k].ev, segs[k].eg});
    end
    reset = 1'b0; sw = 1'b0; d = 1'b0; win = 1'b0;

    // Exact latency: first high sample at edge j=0, pulse only after edge j=6.
    btn = BE;
    for (int j = 0; j < 10; j++) begin
      cyc();
      check($sformatf("latency e j=%0d", j), {n, s, e, w}, {1'b0, 1'b0, (j == 6), 1'b0});
    end
    btn = '0;
    repeat (12) cyc();

    // Reset landing on the pulse cycle clears it immediately.
    btn = BN;
    repeat (7) cyc();
    check("pulse before reset", n, 1'b1);
    reset = 1'b1;
    cyc();
    check("reset mid-pulse", {n, s, e, w, v, game_over}, 6'b0);
    reset = 1'b0; btn = '0;
    repeat (10) cyc();

    // Randomized traffic with held levels, single-cycle glitches and rare events.
    begin
      logic [3:0] lvl;
      lvl = '0;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 11) == 0) begin
          case ($urandom_range(0, 5))
            0, 1:    lvl = '0;
            2, 3, 4: lvl = 4'b0001 << $urandom_range(0, 3);
            default: lvl = 4'($urandom_range(0, 15));
          endcase
        end
        btn = lvl;
        if ($urandom_range(0, 19) == 0) btn[$urandom_range(0, 3)] ^= 1'b1;
        sw    = ($urandom_range(0, 149) == 0);
        d     = ($urandom_range(0, 999) == 0);
        win   = ($urandom_range(0, 999) == 0);
        reset = ($urandom_range(0, 599) == 0);
        cyc();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
